// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset release sequencer.
package reset_seq_pkg;

    // Widest branch count the index helper handles
    localparam int MAX_OUT = 32;

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        RELEASE  = 3'd1,
        WAIT_ACK = 3'd2,
        GAP      = 3'd3,
        RUN      = 3'd4
    } state_t;

    // Lowest set bit position of mask; 0 when mask is empty
    function automatic logic [4:0] first_set_idx(input logic [MAX_OUT-1:0] mask);
        logic [4:0] idx;
        idx = '0;
        for (int i = MAX_OUT - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/reset_release_sequencer_if.sv
// Handshake bundle between the reset sequencer and the downstream domains.
// master: the sequencer; slave: the software/domain side driving requests and acks.
interface reset_release_sequencer_if #(
    parameter int NUM_OUT = 3
);
    logic               sw_reset_req;
    logic [NUM_OUT-1:0] sw_reset_mask;
    logic [NUM_OUT-1:0] ready_ack;
    logic [NUM_OUT-1:0] out_reset_n;
    logic               busy;
    logic               done;
    logic               timeout_err;

    modport master (
        input  sw_reset_req,
        input  sw_reset_mask,
        input  ready_ack,
        output out_reset_n,
        output busy,
        output done,
        output timeout_err
    );

    modport slave (
        output sw_reset_req,
        output sw_reset_mask,
        output ready_ack,
        input  out_reset_n,
        input  busy,
        input  done,
        input  timeout_err
    );
endinterface

// File: rtl/reset_seq_counter.sv
// Shared stage counter: synchronous clear (priority), enable, terminal-count flag.
module reset_seq_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             tc_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear on every state entry, otherwise count while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/reset_release_sequencer.sv
// Staggered reset release controller for the clock/reset fan-out tile.
// Optional feature macro: RESET_SEQ_ACK_TIMEOUT_EN (bounded ack wait + sticky timeout_err).
module reset_release_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_OUT        = 3,
    parameter int STAGGER_CYCLES = 4,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                        clock,
    input logic                        reset_n,
    reset_release_sequencer_if.master  bus
);
    localparam int               IDX_W        = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [CNT_W-1:0] STAGGER_TERM = CNT_W'(STAGGER_CYCLES - 1);

    // Elaboration-time parameter sanity
    if (NUM_OUT < 1 || NUM_OUT > MAX_OUT || STAGGER_CYCLES < 1 ||
        STAGGER_CYCLES >= (2 ** CNT_W) || TIMEOUT_CYCLES < 1 ||
        TIMEOUT_CYCLES >= (2 ** CNT_W)) begin : g_bad_param
        $error("reset_release_sequencer: illegal parameter combination");
    end

    state_t             state_q, state_d;
    logic [NUM_OUT-1:0] out_q, out_d;
    logic [NUM_OUT-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [NUM_OUT-1:0] idx_oh;
    logic [IDX_W-1:0]   rel_idx;
    logic               ack_hit;
    logic               tmo_hit;
    logic               sw_accept;
    logic               cnt_clr;
    logic               cnt_en;
    logic [CNT_W-1:0]   cnt_term;
    logic               cnt_tc;

    assign idx_oh    = NUM_OUT'(1) << idx_q;
    assign rel_idx   = IDX_W'(first_set_idx(MAX_OUT'(mask_q)));
    assign ack_hit   = (state_q == WAIT_ACK) && ((bus.ready_ack & idx_oh) != '0);
    assign sw_accept = (state_q == RUN) && bus.sw_reset_req && (bus.sw_reset_mask != '0);
    assign cnt_clr   = (state_d != state_q);

`ifdef RESET_SEQ_ACK_TIMEOUT_EN
    logic err_q;

    assign cnt_en   = (state_q == HOLD) || (state_q == GAP) || (state_q == WAIT_ACK);
    assign cnt_term = (state_q == WAIT_ACK) ? CNT_W'(TIMEOUT_CYCLES - 1) : STAGGER_TERM;
    assign tmo_hit  = (state_q == WAIT_ACK) && cnt_tc && !ack_hit;

    // Sticky timeout flag; only block reset clears it
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (tmo_hit) begin
            err_q <= 1'b1;
        end
    end

    assign bus.timeout_err = err_q;
`else
    assign cnt_en          = (state_q == HOLD) || (state_q == GAP);
    assign cnt_term        = STAGGER_TERM;
    assign tmo_hit         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    reset_seq_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .term_i  (cnt_term),
        .tc_o    (cnt_tc)
    );

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            HOLD:     if (cnt_tc) state_d = RELEASE;
            RELEASE:  state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (ack_hit || tmo_hit) begin
                    state_d = ((mask_q & ~idx_oh) == '0) ? RUN : GAP;
                end
            end
            GAP:      if (cnt_tc) state_d = RELEASE;
            RUN:      if (sw_accept) state_d = HOLD;
            default:  state_d = HOLD;
        endcase
    end

    // Output/datapath next values; released branches stay high unless re-reset
    always_comb begin
        out_d  = out_q;
        mask_d = mask_q;
        idx_d  = idx_q;
        case (state_q)
            RELEASE: begin
                idx_d = rel_idx;
                out_d = out_q | (NUM_OUT'(1) << rel_idx);
            end
            WAIT_ACK: begin
                if (ack_hit || tmo_hit) begin
                    mask_d = mask_q & ~idx_oh;
                end
            end
            RUN: begin
                if (sw_accept) begin
                    out_d  = out_q & ~bus.sw_reset_mask;
                    mask_d = bus.sw_reset_mask;
                end
            end
            default: ;
        endcase
        busy_d = (state_d != RUN);
        done_d = (state_d == RUN);
    end

    // Registered outputs and sequencing registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_q  <= '0;
            mask_q <= '1;
            idx_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            mask_q <= mask_d;
            idx_q  <= idx_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.out_reset_n = out_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule
